qdivider: RTL

QDIVIDER -- requirements
Module: qdivider

---
 rtl/qdiv_pkg.sv | 13 +
 rtl/qdiv_step.sv | 29 ++
 rtl/qdivider.sv | 120 ++++++++++++
 3 files changed

// File: rtl/qdiv_pkg.sv
// Shared definitions for the restoring divider: FSM state type and default widths.
package qdiv_pkg;

  localparam int QDIV_DW = 13;
  localparam int QDIV_KW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } qdiv_state_e;

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, emit the quotient bit.
module qdiv_step
  import qdiv_pkg::*;
#(
  parameter int KW = QDIV_KW
) (
  input  logic [KW:0]   rem_in,
  input  logic          bit_in,
  input  logic [KW-1:0] divisor,
  output logic [KW:0]   rem_out,
  output logic          qbit
);

  logic [KW:0] shifted;
  logic [KW:0] diff;
  logic        fits;

  // The MSB of rem_in falls off the shift; if it was set the shifted value
  // is at least 2^(KW+1), which always exceeds the divisor.
  always_comb begin
    shifted = {rem_in[KW-1:0], bit_in};
    diff    = shifted - {1'b0, divisor};
    fits    = rem_in[KW] | (shifted >= {1'b0, divisor});
    rem_out = fits ? diff : shifted;
    qbit    = fits;
  end

endmodule

// File: rtl/qdivider.sv
// Sequential unsigned divider: one restoring step per clock, MSB first.
// Divide-by-zero short-circuits to DONE with an all-ones quotient.
//
//   state | meaning
//   IDLE  | waiting for i_start; operands latched on acceptance
//   CALC  | one restoring step per cycle, cnt counts DW-1 down to 0
//   DONE  | results registered, o_valid high for this single cycle
module qdivider
  import qdiv_pkg::*;
#(
  parameter int DW = QDIV_DW,
  parameter int KW = QDIV_KW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] A,
  input  logic [KW-1:0] k,
  output logic          o_busy,
  output logic          o_valid,
  output logic [DW-1:0] o_quot,
  output logic [KW-1:0] o_rem,
  output logic          o_dz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  qdiv_state_e   state, state_nxt;

  // aq starts as the dividend; quotient bits shift in at the LSB as the
  // dividend bits shift out of the MSB, so one register serves both.
  logic [DW-1:0] aq;
  logic [KW-1:0] k_q;
  logic [KW:0]   rem_q;
  logic [CW-1:0] cnt;

  logic [KW:0]   rem_nxt;
  logic          qbit;
  logic          last_step;

  assign last_step = (cnt == '0);

  qdiv_step #(.KW(KW)) u_step (
    .rem_in  (rem_q),
    .bit_in  (aq[DW-1]),
    .divisor (k_q),
    .rem_out (rem_nxt),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_start) state_nxt = (k == '0) ? DONE : CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs; gated by reset so a pending DONE never leaks a pulse.
  always_comb begin
    o_busy  = 1'b0;
    o_valid = 1'b0;
    if (!i_rst) begin
      o_busy  = (state == CALC) || (state == DONE);
      o_valid = (state == DONE);
    end
  end

  // Operand latch, restoring iteration and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      aq     <= '0;
      k_q    <= '0;
      rem_q  <= '0;
      cnt    <= '0;
      o_quot <= '0;
      o_rem  <= '0;
      o_dz   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            if (k == '0) begin
              o_quot <= '1;
              o_rem  <= '0;
              o_dz   <= 1'b1;
            end else begin
              aq    <= A;
              k_q   <= k;
              rem_q <= '0;
              cnt   <= CW'(DW - 1);
            end
          end
        end
        CALC: begin
          aq    <= {aq[DW-2:0], qbit};
          rem_q <= rem_nxt;
          if (last_step) begin
            o_quot <= {aq[DW-2:0], qbit};
            o_rem  <= rem_nxt[KW-1:0];
            o_dz   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
